asy_nbit_sync_filter: RTL
=========================

Name: asy_nbit_sync_filter

Overview:
Multi-channel input conditioner for asynchronous single-bit signals entering one clock domain.
- Each channel has a parametrised-depth synchroniser chain and an optional glitch filter (consecutive-cycle stability counter).
- Each channel produces the filtered level, rise/fall pulses, a runtime-selectable event pulse, and a clearable sticky event flag.
- Sits at the boundary between external or slow-domain status/strobe lines and fast-domain control logic. Generalises the single-channel rising-edge synchroniser.

Parameters:
CH, 4, number of independent channels (≥1)
SYNC_STAGES, 2, synchroniser flops per channel (≥2); all carry ASYNC_REG
FILT_LEN, 4, consecutive cycles a synchronised value must differ from the filtered level before the level changes; 0 = filter bypassed

Ports:
clk_fast  in  1  destination/sampling clock; sole clock of the block
rst_n  in  1  asynchronous active-low reset
din  in  CH  asynchronous inputs, one bit per channel
edge_sel  in  2*CH  per-channel event select, bits [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both
sticky_clr  in  CH  per-channel synchronous clear of evt_sticky
level_out  out  CH  filtered, synchronised level
rise_pulse  out  CH  1-cycle pulse on level_out 0→1
fall_pulse  out  CH  1-cycle pulse on level_out 1→0
evt_pulse  out  CH  1-cycle pulse per edge_sel
evt_sticky  out  CH  latched event flag

Behaviour:
- Clock and reset: one clock, clk_fast; reset is asynchronous and active-low on rst_n.
- Reset values: all sync flops, filter counters, filtered level L and delayed level L_q go to 0. Every output is therefore 0 during reset.
- Channels are fully independent; no shared state.
- Sync chain:
  - s = output of stage SYNC_STAGES.
  - din reaches s SYNC_STAGES edges after the first sampling edge.
- Filter, FILT_LEN ≥ 1, counter width clog2(FILT_LEN+1), evaluated each edge:
  - If s == L: cnt ← 0.
  - Else if cnt == FILT_LEN-1: L ← s, cnt ← 0.
  - Else: cnt ← cnt+1.
- Filter consequences:
  - Level latency is SYNC_STAGES+FILT_LEN edges from the first sampling edge.
  - An s excursion lasting FILT_LEN cycles passes; one lasting FILT_LEN-1 or fewer cycles is rejected, and cnt returns to 0.
- Filter bypass, FILT_LEN = 0: no counter is instantiated; L is s, with no extra register.
- Outputs:
  - level_out = L.
  - L_q = L delayed one clk_fast cycle.
  - rise_pulse = L & ~L_q and fall_pulse = ~L & L_q, both combinational. Each asserts for exactly one cycle, in the same cycle level_out first shows the new value.
- evt_pulse:
  - evt_pulse[i] = (edge_sel[2i] & rise_pulse[i]) | (edge_sel[2i+1] & fall_pulse[i]), combinational.
  - edge_sel is used live; a change takes effect immediately.
- evt_sticky, per channel:
  - Set on evt_pulse; cleared on sticky_clr.
  - Set and clear in the same cycle: set wins, so the flag stays 1.
  - Otherwise it holds.
- Reset mid-operation: all in-flight state is discarded.
  - If din is high when rst_n deasserts, L rises after the normal latency and one rise_pulse is produced. This is intended: the post-reset level is 0.
- Back-to-back edges: with FILT_LEN = 0 and a din toggling every cycle, rise and fall pulses alternate each cycle. No pulse is merged or lost once a transition reaches s.
- Metastability: only stage 1 may go metastable. Nothing downstream observes stage 1 except stage 2.

Test Plan:
1. Basic latency (CH=4, SYNC_STAGES=2, FILT_LEN=4): din[0] 0→1 held before edge 1.
   - level_out[0] =1 after edge 6.
   - rise_pulse[0] high for exactly the cycle after edge 6.
   - Other channels stay 0.
2. Glitch rejection: din[1] high for exactly 3 sampled cycles → level_out[1], rise_pulse[1], fall_pulse[1] never assert. Then high for 4 cycles → level_out[1] high for 4 cycles, one rise and one fall pulse.
3. Edge select:
   - edge_sel = 8'b11_10_01_00; drive a full 0→1→0 on all four channels.
   - Required evt_pulse counts per channel: ch0=0, ch1=1 (rise), ch2=1 (fall), ch3=2.
   - Switch edge_sel[1:0] to 01 mid-test → ch0 pulses on its next rise.
4. Sticky flags:
   - After scenario 3, evt_sticky = 4'b1110.
   - sticky_clr=4'b0010 for one cycle → 4'b1100.
   - Assert sticky_clr[3] in the same cycle as an evt_pulse[3] → evt_sticky[3] remains 1.
5. Reset mid-filter:
   - din[2]=1, assert rst_n low after edge 4 (cnt nonzero) → all outputs 0 immediately.
   - Release with din[2] still 1 → level_out[2] rises 6 edges after release, with one rise_pulse.
6. Bypass build (FILT_LEN=0, SYNC_STAGES=3): din[0] toggles every cycle → level_out[0] follows with 3-edge latency; rise_pulse and fall_pulse alternate every cycle with no gaps.

Source files
------------

// File: rtl/asy_nbit_sync_filter.sv
// Multi-channel conditioner for async 1-bit inputs: sync chain, optional glitch filter, edge/event pulses, sticky flag.
// Latency: din to level_out is SYNC_STAGES+FILT_LEN clk_fast edges; pulses are combinational from the level.
// Backpressure: none; every channel samples every cycle, so outputs are plain levels and one-cycle pulses.
module asy_nbit_sync_filter #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic              clk_fast,
    input  logic              rst_n,
    input  logic [CH-1:0]     din,
    input  logic [2*CH-1:0]   edge_sel,
    input  logic [CH-1:0]     sticky_clr,
    output logic [CH-1:0]     level_out,
    output logic [CH-1:0]     rise_pulse,
    output logic [CH-1:0]     fall_pulse,
    output logic [CH-1:0]     evt_pulse,
    output logic [CH-1:0]     evt_sticky
);

    logic [CH-1:0] sync_s;
    logic [CH-1:0] filt_lvl;
    logic [CH-1:0] lvl_dly_q, lvl_dly_d;
    logic [CH-1:0] sticky_q, sticky_d;
    logic [CH-1:0] rise, fall, evt;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
        logic [SYNC_STAGES-1:0] sync_d;

        // Shift din into the chain; only stage 1 can go metastable and only stage 2 reads it.
        always_comb begin
            sync_d = {sync_q[SYNC_STAGES-2:0], din[i]};
        end

        // Synchroniser flops.
        always_ff @(posedge clk_fast or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= sync_d;
            end
        end

        assign sync_s[i] = sync_q[SYNC_STAGES-1];

        if (FILT_LEN == 0) begin : g_bypass
            assign filt_lvl[i] = sync_s[i];
        end else begin : g_filt
            localparam int            CW       = $clog2(FILT_LEN + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

            logic [CW-1:0] cnt_q, cnt_d;
            logic          lvl_q, lvl_d;

            // Level follows s only after FILT_LEN consecutive disagreeing samples; any agreement restarts the count.
            always_comb begin
                cnt_d = cnt_q;
                lvl_d = lvl_q;
                if (sync_s[i] == lvl_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    lvl_d = sync_s[i];
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Filter state.
            always_ff @(posedge clk_fast or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                    lvl_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    lvl_q <= lvl_d;
                end
            end

            assign filt_lvl[i] = lvl_q;
        end
    end

    // Edge detect against the one-cycle-delayed level, event select (live edge_sel), sticky with set priority.
    always_comb begin
        lvl_dly_d = filt_lvl;
        rise      = filt_lvl & ~lvl_dly_q;
        fall      = ~filt_lvl & lvl_dly_q;
        evt       = '0;
        for (int i = 0; i < CH; i++) begin
            evt[i] = (edge_sel[2*i] & rise[i]) | (edge_sel[2*i+1] & fall[i]);
        end
        sticky_d = evt | (sticky_q & ~sticky_clr);
    end

    // Delayed level and sticky flags.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            lvl_dly_q <= '0;
            sticky_q  <= '0;
        end else begin
            lvl_dly_q <= lvl_dly_d;
            sticky_q  <= sticky_d;
        end
    end

    assign level_out  = filt_lvl;
    assign rise_pulse = rise;
    assign fall_pulse = fall;
    assign evt_pulse  = evt;
    assign evt_sticky = sticky_q;

endmodule
